// File: rtl/mem_port_arbiter.sv
// Round-robin front end that serialises NUM_CH requesters onto one memory port,
// with per-channel completion/error pulses and a programmable response timeout.
module mem_port_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_gnt,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [NUM_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       cs,
    output logic                       read_req,
    output logic                       write_req,
    output logic [ADDR_W-1:0]          addrout,
    output logic [DATA_W-1:0]          datatomem,
    input  logic [DATA_W-1:0]          datafrommem,
    input  logic                       mem_resp
);

    localparam int unsigned PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win;
    logic               acc_we;
    logic [CNT_W-1:0]   cnt;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   scan_idx;

    logic [ADDR_W-1:0]  addr_arr  [NUM_CH];
    logic [DATA_W-1:0]  wdata_arr [NUM_CH];

    // Split the flat channel buses into per-channel slices.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_arr[i]  = ch_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = ch_wdata[i*DATA_W +: DATA_W];
    end

    // Round-robin pick: first requester found scanning upward from ptr+1 with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            scan_idx = PTR_W'((int'(ptr) + k) % int'(NUM_CH));
            if (!win_found && ch_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Arbitration FSM with registered memory strobes and channel pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= PTR_W'(NUM_CH - 1);
            win       <= '0;
            acc_we    <= 1'b0;
            cnt       <= '0;
            ch_gnt    <= '0;
            ch_done   <= '0;
            ch_err    <= '0;
            ch_rdata  <= '0;
            cs        <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            addrout   <= '0;
            datatomem <= '0;
        end else begin
            ch_gnt  <= '0;
            ch_done <= '0;
            ch_err  <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        win             <= win_idx;
                        acc_we          <= ch_we[win_idx];
                        addrout         <= addr_arr[win_idx];
                        datatomem       <= wdata_arr[win_idx];
                        cnt             <= '0;
                        cs              <= 1'b1;
                        read_req        <= !ch_we[win_idx];
                        write_req       <= ch_we[win_idx];
                        ch_gnt[win_idx] <= 1'b1;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response in the same cycle as the timeout wins.
                    if (mem_resp) begin
                        if (!acc_we) begin
                            ch_rdata <= datafrommem;
                        end
                        ch_done[win] <= 1'b1;
                        cs           <= 1'b0;
                        read_req     <= 1'b0;
                        write_req    <= 1'b0;
                        state        <= RESP;
                    end else if (TO_EN && (cnt == CNT_W'(TO_LAST))) begin
                        ch_rdata     <= '0;
                        ch_done[win] <= 1'b1;
                        ch_err[win]  <= 1'b1;
                        cs           <= 1'b0;
                        read_req     <= 1'b0;
                        write_req    <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= win;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised multi-channel memory front end for the processor subsystem. It accepts read/write requests from NUM_CH independent requesters and arbitrates them round-robin onto the single memory port (cs, read_req, write_req, addrout, datatomem, datafrommem, mem_resp). It returns per-channel completion and read data, and aborts any access that exceeds a programmable response timeout.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- DATA_W, 16, memory data width
- ADDR_W, 14, memory address width
- TIMEOUT, 255, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- ch_req  in  NUM_CH  per-channel request level
- ch_we  in  NUM_CH  1 = write, 0 = read; sampled with ch_req
- ch_addr  in  NUM_CH*ADDR_W  channel i address at bits [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*DATA_W  channel i write data, packed the same way as ch_addr
- ch_gnt  out  NUM_CH  one-cycle pulse: request accepted
- ch_done  out  NUM_CH  one-cycle pulse: transaction complete
- ch_err  out  NUM_CH  one-cycle pulse, coincident with ch_done: timeout abort
- ch_rdata  out  DATA_W  shared read data, valid while ch_done is high
- cs  out  1  memory chip select
- read_req  out  1  memory read strobe
- write_req  out  1  memory write strobe
- addrout  out  ADDR_W  memory address
- datatomem  out  DATA_W  memory write data
- datafrommem  in  DATA_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion

## Operation
- All outputs are registered.
- The FSM has three states: IDLE, ACCESS and RESP. Only one transaction is outstanding at a time.
- **IDLE:**
  - If any ch_req bit is high, pick winner w by round-robin. Priority starts at (ptr+1) mod NUM_CH and ascends with wrap.
  - Latch ch_we[w], the address slice and the wdata slice into addrout, datatomem and a we register.
  - Clear the timeout counter and go to ACCESS.
- **ACCESS:**
  - cs = 1, read_req = !we, write_req = we. ch_gnt[w] is high on the first ACCESS cycle only.
  - The counter increments each ACCESS cycle.
  - mem_resp high: if we = 0, capture datafrommem into ch_rdata; go to RESP with err = 0.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1: go to RESP with err = 1 and force ch_rdata to 0.
- **RESP:**
  - cs, read_req and write_req are 0.
  - ch_done[w] = 1; ch_err[w] = err.
  - Set ptr = w and go to IDLE.
- ch_rdata holds its last value across writes. It changes only on read completion, timeout (forced to 0) or reset.
- addrout and datatomem hold their latched values after the transaction; only cs qualifies them.
- A ch_req bit high in IDLE is always a new request. A requester must drop ch_req no later than the cycle its ch_done pulses, or it is re-served.
- Once a request is sampled in IDLE it is committed; withdrawing ch_req afterwards has no effect.
- mem_resp is ignored outside ACCESS.
- If mem_resp and the timeout condition occur in the same cycle, the response wins (err = 0).

## Timing
- Reset values:
  - ch_gnt, ch_done, ch_err, ch_rdata, cs, read_req, write_req, addrout and datatomem are all 0.
  - ptr = NUM_CH-1, so channel 0 has highest priority first. State = IDLE, counter = 0.
- Reset mid-transaction: the next cycle shows all reset values. The in-flight transaction is dropped with no ch_done.
- Latency:
  - ch_req sampled in cycle 0 (IDLE) → cycle 1: ch_gnt pulse, cs and strobe asserted.
  - mem_resp sampled high in cycle n → cycle n+1: ch_done and ch_rdata valid, cs low.
  - cycle n+2: IDLE, where the next arbitration is sampled.
- Best case is a 3-cycle period per transaction, with mem_resp arriving in the first ACCESS cycle.
- Timeout: ACCESS lasts at most TIMEOUT cycles, i.e. cycles 1..TIMEOUT. ch_done/ch_err pulse in cycle TIMEOUT+1.
- Counter width is $clog2(TIMEOUT+1), minimum 1.

## Test plan
- **Single read:** ch2 reads addr 0x0123; mem_resp with datafrommem = 0xBEEF in the 3rd ACCESS cycle → ch_gnt[2] in cycle 1, read_req high for cycles 1–3, ch_done[2] in cycle 4 with ch_rdata = 0xBEEF and ch_err = 0.
- **Write:** ch0 writes 0xA5A5 to 0x3FFF; mem_resp in the first ACCESS cycle → write_req, addrout = 0x3FFF, datatomem = 0xA5A5 in cycle 1; ch_done[0] in cycle 2; ch_rdata unchanged.
- **Round-robin:** all four ch_req held high from reset; memory responds immediately; each channel drops its request on ch_done, then re-raises it → grant order 0,1,2,3,0,1; grants spaced 3 cycles apart.
- **Timeout:** TIMEOUT = 8; ch1 reads; no mem_resp → cs high for exactly 8 cycles; ch_done[1] and ch_err[1] in cycle 9 with ch_rdata = 0; a pending ch3 request is granted afterwards.
- **Reset mid-access:** reset_n low during the 2nd ACCESS cycle of a ch2 read → all outputs 0 the next cycle and no ch_done; after release with ch0 and ch2 both requesting, ch0 is granted first.
- **Edge cases:**
  - mem_resp on ACCESS cycle 8 with TIMEOUT = 8 → ch_done without ch_err.
  - mem_resp pulsed while in IDLE → no output change.
